// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse width meter and its synchronizer.
// Optional build macro used by this block: PW_GLITCH_FILTER_EN.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } pw_state_e;

    localparam int unsigned SYNC_STAGES = 2;

    // Number of bits needed to hold a saturating count of 0..max_width.
    function automatic int unsigned width_bits(input int unsigned max_width);
        return $clog2(max_width + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; flops clear to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/pulse_width_meter.sv
// Measures the width of each high pulse on pulse_in in clk cycles, with saturation.
// Build macro PW_GLITCH_FILTER_EN drops pulses shorter than MIN_WIDTH.
module pulse_width_meter
    import pulse_pkg::*;
#(
    parameter int unsigned MAX_WIDTH = 1000,
    parameter int unsigned MIN_WIDTH = 3,
    localparam int unsigned WB = width_bits(MAX_WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pulse_in,
    input  logic          clear,
    output logic [WB-1:0] width,
    output logic          valid,
    output logic          overflow,
    output logic          busy
);

    localparam int unsigned FW = $clog2(SYNC_STAGES + 1);

`ifdef PW_GLITCH_FILTER_EN
    localparam logic [WB-1:0] REPORT_MIN = WB'(MIN_WIDTH);
`else
    localparam logic [WB-1:0] REPORT_MIN = WB'(1);
`endif

    generate
        if (MAX_WIDTH < 2 || MIN_WIDTH < 1 || MIN_WIDTH > MAX_WIDTH) begin : g_bad_params
            $error("pulse_width_meter: need MAX_WIDTH >= 2 and 1 <= MIN_WIDTH <= MAX_WIDTH");
        end
    endgenerate

    logic s2;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pulse_in),
        .q     (s2)
    );

    pw_state_e     state_q, state_d;
    logic [WB-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [WB-1:0] width_q, width_d;
    logic          overflow_q, overflow_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          sync_ok;

    // s2 only reflects pulse_in once the synchronizer has been refilled after
    // reset; until then IDLE must not treat its reset zero as a real low level.
    always_comb begin
        sync_ok = (fill_q == FW'(SYNC_STAGES));
        fill_d  = sync_ok ? fill_q : fill_q + FW'(1);
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        width_d    = width_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sync_ok && !s2) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (s2) begin
                    count_d = WB'(1);
                    ovf_d   = 1'b0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (s2) begin
                    if (count_q < WB'(MAX_WIDTH)) begin
                        count_d = count_q + WB'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    if (count_q >= REPORT_MIN) begin
                        width_d    = count_q;
                        overflow_d = ovf_q;
                        valid_d    = 1'b1;
                    end
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = ARMED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == MEASURE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end

        if (!rst_n || clear) begin
            state_q    <= IDLE;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            width_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            width_q    <= width_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign width    = width_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed and randomized pulse trains checked against a per-pulse width model.
module tb_pulse_width_meter;

    localparam int unsigned MAX_W = 16;
    localparam int unsigned MIN_W = 3;
    localparam int unsigned WB    = $clog2(MAX_W + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pulse_in = 1'b0;
    logic          clear = 1'b0;
    logic [WB-1:0] width;
    logic          valid;
    logic          overflow;
    logic          busy;

    always #5 clk = ~clk;

    pulse_width_meter #(
        .MAX_WIDTH (MAX_W),
        .MIN_WIDTH (MIN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pulse_in (pulse_in),
        .clear    (clear),
        .width    (width),
        .valid    (valid),
        .overflow (overflow),
        .busy     (busy)
    );

    int            vectors = 0;
    int            miscompares = 0;
    logic [WB-1:0] exp_q[$];
    logic          exp_ovf_q[$];
    logic [WB-1:0] last_w = '0;
    logic          last_o = 1'b0;
    logic          prev_valid = 1'b0;
    int            busy_cycles = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: a pulse of n high cycles reports min(n, MAX_W), overflow iff n > MAX_W.
    task automatic expect_pulse(input int n);
`ifdef PW_GLITCH_FILTER_EN
        if (n < int'(MIN_W)) return;
`endif
        exp_q.push_back((n > int'(MAX_W)) ? WB'(MAX_W) : WB'(n));
        exp_ovf_q.push_back(n > int'(MAX_W));
    endtask

    // One clock: sample outputs at the falling edge, then drive the next input.
    task automatic step(input logic pin);
        logic [WB-1:0] w;
        logic          o;
        @(negedge clk);
        if (valid) begin
            check("valid_gap", prev_valid, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", valid, 0);
            end else begin
                w = exp_q.pop_front();
                o = exp_ovf_q.pop_front();
                check("width", width, w);
                check("overflow", overflow, o);
                last_w = w;
                last_o = o;
            end
        end
        prev_valid = valid;
        if (busy) busy_cycles++;
        pulse_in = pin;
    endtask

    task automatic drive_pulse(input int n, input int gap);
        expect_pulse(n);
        repeat (n) step(1'b1);
        repeat (gap) step(1'b0);
    endtask

    task automatic forget_reports();
        exp_q.delete();
        exp_ovf_q.delete();
        last_w = '0;
        last_o = 1'b0;
    endtask

    initial begin
        int n;
        int gap;

        repeat (4) step(1'b0);
        check("rst_width", width, 0);
        check("rst_valid", valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (5) step(1'b0);

        busy_cycles = 0;
        drive_pulse(10, 6);
        check("t1_pending", exp_q.size(), 0);
        check("t1_busy_cycles", busy_cycles, 10);
        check("t1_width", width, last_w);
        check("t1_overflow", overflow, last_o);

        step(1'b1);
        rst_n = 1'b0;
        repeat (4) step(1'b1);
        rst_n = 1'b1;
        forget_reports();
        repeat (20) step(1'b1);
        repeat (6) step(1'b0);
        check("t2_held_width", width, 0);
        drive_pulse(5, 6);
        check("t2_pending", exp_q.size(), 0);
        check("t2_width", width, 5);

        drive_pulse(16, 6);
        check("t3_exact_width", width, 16);
        check("t3_exact_ovf", overflow, 0);
        drive_pulse(40, 6);
        check("t3_long_width", width, 16);
        check("t3_long_ovf", overflow, 1);

        drive_pulse(4, 1);
        drive_pulse(7, 6);
        check("t4_pending", exp_q.size(), 0);
        check("t4_width", width, 7);

        repeat (4) step(1'b1);
        step(1'b1);
        clear = 1'b1;
        step(1'b1);
        clear = 1'b0;
        forget_reports();
        repeat (6) step(1'b1);
        repeat (6) step(1'b0);
        check("t5_width", width, 0);
        check("t5_overflow", overflow, 0);
        check("t5_busy", busy, 0);
        drive_pulse(3, 6);
        check("t5_next_width", width, 3);

        drive_pulse(2, 6);
        check("t6_short_pending", exp_q.size(), 0);
        check("t6_short_width", width, last_w);
        drive_pulse(3, 6);
        check("t6_width", width, 3);

        repeat (30) begin
            n   = $urandom_range(1, 40);
            gap = $urandom_range(1, 4);
            drive_pulse(n, gap);
        end
        repeat (8) step(1'b0);
        check("rand_pending", exp_q.size(), 0);
        check("rand_width", width, last_w);
        check("rand_overflow", overflow, last_o);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
